// File: rtl/stop_watch_bcd_n.sv
// ---------------------------------------------------------------------------
// stop_watch_bcd_n
//
// N-digit BCD stopwatch/timer. A prescaler divides the enabled clock down to
// one count tick every DVSR clocks. On each tick a BCD digit cascade counts
// up (wrapping all-9s -> all-0s) or down (stopping at all-0s). Also provides
// preset load with per-digit saturation, wrap/done pulses and an optional
// lap-hold display register.
//
// Optional feature macro: SW_LAP_EN
//   defined   : adds the 'lap' input; each lap pulse toggles a frozen display.
//   undefined : no lap input, lap_active tied 0, disp = cnt.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset_n    in   asynchronous active-low reset
//   go         in   run enable (0 = pause, prescaler and digits hold)
//   clr        in   synchronous clear of prescaler, digits and lap hold
//   up         in   count direction, sampled at each tick (1 = up)
//   load       in   synchronous preset of digits from load_val
//   load_val   in   preset value, packed BCD, digit i at [4i+3:4i]
//   lap        in   (SW_LAP_EN only) lap toggle pulse
//   disp       out  displayed value: lap register while frozen, else cnt
//   cnt        out  live count, packed BCD
//   running    out  go & ~clr
//   wrap       out  one-cycle pulse after an up-count rolls all-9s -> all-0s
//   done       out  one-cycle pulse after a down-count reaches all-0s
//   lap_active out  display currently frozen
// ---------------------------------------------------------------------------
module stop_watch_bcd_n #(
  parameter int DIGITS = 4,
  parameter int DVSR   = 5000000,
  parameter int PS_W   = 23
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic                clr,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef SW_LAP_EN
  input  logic                lap,
`endif
  output logic [4*DIGITS-1:0] disp,
  output logic [4*DIGITS-1:0] cnt,
  output logic                running,
  output logic                wrap,
  output logic                done,
  output logic                lap_active
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [PS_W-1:0] ps;
  logic [W-1:0]    cnt_q;
  logic            wrap_q;
  logic            done_q;
  logic            tick;

  logic [W-1:0]    cnt_step;   // count after one tick in the current direction
  logic [W-1:0]    load_sat;   // load_val with each digit clamped to 9
  logic            wrap_set;
  logic            done_set;

  assign tick    = go && (ps == PS_W'(DVSR - 1));
  assign running = go & ~clr;
  assign cnt     = cnt_q;
  assign wrap    = wrap_q;
  assign done    = done_q;

  // Digit cascade: a carry (up) or borrow (down) ripples from digit 0 and
  // moves digit i only while every lower digit rolled over.
  always_comb begin
    logic       ripple;
    logic [3:0] d;
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would infer a latch.
    cnt_step = cnt_q;
    load_sat = '0;
    ripple   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = cnt_q[4*i +: 4];
      if (ripple) begin
        if (up) begin
          if (d == 4'd9) cnt_step[4*i +: 4] = 4'd0;
          else begin
            cnt_step[4*i +: 4] = d + 4'd1;
            ripple = 1'b0;
          end
        end else begin
          if (d == 4'd0) cnt_step[4*i +: 4] = 4'd9;
          else begin
            cnt_step[4*i +: 4] = d - 4'd1;
            ripple = 1'b0;
          end
        end
      end
      d = load_val[4*i +: 4];
      load_sat[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
    end
    // Down-count parks at zero: no borrow into all-9s.
    if (!up && cnt_q == '0) cnt_step = cnt_q;
    wrap_set = up && (cnt_q == ALL_NINES);
    done_set = !up && (cnt_q != '0) && (cnt_step == '0);
  end

  // Priority: clr > load > tick > hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps     <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (clr) begin
        ps    <= '0;
        cnt_q <= '0;
      end else if (load) begin
        ps    <= '0;
        cnt_q <= load_sat;
      end else if (tick) begin
        ps     <= '0;
        cnt_q  <= cnt_step;
        wrap_q <= wrap_set;
        done_q <= done_set;
      end else if (go) begin
        ps <= ps + PS_W'(1);
      end
    end
  end

`ifdef SW_LAP_EN
  logic [W-1:0] lap_q;
  logic         lap_active_q;

  // The freeze captures cnt as it stands before this edge, so a coinciding
  // tick is shown on the live count only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else if (clr) begin
      lap_q        <= '0;
      lap_active_q <= 1'b0;
    end else if (lap) begin
      lap_active_q <= ~lap_active_q;
      if (!lap_active_q) lap_q <= cnt_q;
    end
  end

  assign lap_active = lap_active_q;
  assign disp       = lap_active_q ? lap_q : cnt_q;
`else
  assign lap_active = 1'b0;
  assign disp       = cnt_q;
`endif

endmodule

// File: tb/tb_stop_watch_bcd_n.sv
// ---------------------------------------------------------------------------
// tb_stop_watch_bcd_n
//
// Scoreboard bench for stop_watch_bcd_n (DIGITS=3, DVSR=4). The driver
// applies inputs on the falling edge, steps a decimal-integer reference model
// and queues the outputs expected after the next rising edge. A monitor pops
// and compares shortly after each rising edge, or right after an
// asynchronous reset assertion. Builds with or without SW_LAP_EN.
// ---------------------------------------------------------------------------
module tb_stop_watch_bcd_n;

  localparam int DIGITS  = 3;
  localparam int DVSR    = 4;
  localparam int PS_W    = 3;
  localparam int W       = 4 * DIGITS;
  localparam int MAX_VAL = 10 ** DIGITS - 1;
`ifdef SW_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         go, clr, up, load, lap;
  logic [W-1:0] load_val;
  logic [W-1:0] disp, cnt;
  logic         running, wrap, done, lap_active;

  stop_watch_bcd_n #(.DIGITS(DIGITS), .DVSR(DVSR), .PS_W(PS_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (go),
    .clr        (clr),
    .up         (up),
    .load       (load),
    .load_val   (load_val),
`ifdef SW_LAP_EN
    .lap        (lap),
`endif
    .disp       (disp),
    .cnt        (cnt),
    .running    (running),
    .wrap       (wrap),
    .done       (done),
    .lap_active (lap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic [W-1:0] disp;
    logic         running;
    logic         wrap;
    logic         done;
    logic         lap_active;
  } exp_t;

  exp_t exp_q[$];
  event async_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: the count as a plain decimal integer.
  int m_val, m_ps, m_lap_val;
  bit m_lap_act, m_wrap, m_done;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int sat_val(input logic [W-1:0] b);
    int v, m, d;
    v = 0;
    m = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * m;
      m *= 10;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
  endtask

  task automatic model_zero();
    m_val = 0; m_ps = 0; m_lap_val = 0;
    m_lap_act = 0; m_wrap = 0; m_done = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit tick;
    if (!reset_n) begin
      model_zero();
      return;
    end
    tick   = go && (m_ps == DVSR - 1);
    m_wrap = 0;
    m_done = 0;
    if (clr) begin
      m_val = 0; m_ps = 0; m_lap_val = 0; m_lap_act = 0;
      return;
    end
    if (LAP_EN && lap) begin
      if (!m_lap_act) m_lap_val = m_val;
      m_lap_act = !m_lap_act;
    end
    if (load) begin
      m_val = sat_val(load_val);
      m_ps  = 0;
    end else if (tick) begin
      m_ps = 0;
      if (up) begin
        if (m_val == MAX_VAL) begin
          m_val  = 0;
          m_wrap = 1;
        end else m_val = m_val + 1;
      end else if (m_val > 0) begin
        m_val  = m_val - 1;
        m_done = (m_val == 0);
      end
    end else if (go) begin
      m_ps = m_ps + 1;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.cnt        = to_bcd(m_val);
    e.disp       = m_lap_act ? to_bcd(m_lap_val) : e.cnt;
    e.running    = go & ~clr;
    e.wrap       = m_wrap;
    e.done       = m_done;
    e.lap_active = m_lap_act;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit i_go, input bit i_clr, input bit i_up, input bit i_load,
                     input logic [W-1:0] i_lv, input bit i_lap, input bit i_rst_n);
    @(negedge clk);
    go = i_go; clr = i_clr; up = i_up; load = i_load;
    load_val = i_lv; lap = i_lap; reset_n = i_rst_n;
    model_step();
    push_exp();
  endtask

  task automatic run(input int n, input bit i_go, input bit i_up);
    for (int k = 0; k < n; k++) cyc(i_go, 1'b0, i_up, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Reset asserted between rising edges: outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_zero();
    push_exp();   // checked immediately
    push_exp();   // checked at the following rising edge
    -> async_ev;
  endtask

  task automatic random_cycles(input int n);
    bit r_up;
    logic [W-1:0] lv;
    logic [W-1:0] pool [5];
    pool[0] = 12'h999; pool[1] = 12'h998; pool[2] = 12'h001;
    pool[3] = 12'h000; pool[4] = 12'h002;
    r_up = up;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 49) == 0) r_up = !r_up;
      if ($urandom_range(0, 1) == 0) lv = W'($urandom);
      else lv = pool[$urandom_range(0, 4)];
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, r_up,
          $urandom_range(0, 39) == 0, lv, $urandom_range(0, 29) == 0, 1'b1);
    end
  endtask

  // Monitor: pop one expectation per observation point and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL no_expect: no queued expectation at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("cnt",        32'(cnt),        32'(e.cnt));
        check("disp",       32'(disp),       32'(e.disp));
        check("running",    32'(running),    32'(e.running));
        check("wrap",       32'(wrap),       32'(e.wrap));
        check("done",       32'(done),       32'(e.done));
        check("lap_active", 32'(lap_active), 32'(e.lap_active));
      end
    end
  end

  initial begin
    reset_n = 1'b0; go = 1'b0; clr = 1'b0; up = 1'b1;
    load = 1'b0; lap = 1'b0; load_val = '0;
    model_zero();
    push_exp();
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);

    // Free run to 0x010, then pause.
    run(40, 1'b1, 1'b1);
    run(10, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1);

    // Up-count wrap from 999.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 12'h999, 1'b0, 1'b1);
    run(12, 1'b1, 1'b1);

    // Down-count borrow, done and hold at zero.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h100, 1'b0, 1'b1);
    run(6, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 1'b1);
    run(20, 1'b1, 1'b0);

    // Saturating load, then clr on a tick cycle.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 12'hA5F, 1'b0, 1'b1);
    run(3, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    run(6, 1'b1, 1'b1);

    // Lap freeze/release, then lap set followed by clr.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    run(20, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    run(4, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    run(3, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1);

    random_cycles(3000);

    // Asynchronous reset mid-count at 0x037, then restart.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 12'h037, 1'b0, 1'b1);
    run(2, 1'b1, 1'b1);
    async_reset();
    for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    run(10, 1'b1, 1'b1);

    random_cycles(1000);

    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
